adc_cmd_parser: RTL
===================

Name: adc_cmd_parser

Overview:
- Parametrised successor to the AD7606 capture-control block.
- Parses byte-stream command frames from the host link (UART/UDP unpacker) into capture configuration registers: channel mask, sample-rate divider, enable, trigger mode and seek pulse.
- Adds length and type checking, abort handling, status pulses and a generic channel/speed width.
- Sits between the command unpacker and the capture core.

Parameters:
- CH_NUM, 8, number of ADC channels; width of the channel mask.
- SPEED_W, 24, width of the sample-rate divider; must be a multiple of 8, from 8 to 32.
- MAX_LEN, 4, maximum accepted payload length in bytes; must be at least SPEED_W/8.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_cmd_data  in  8  command byte
- i_cmd_valid  in  1  byte valid; held high, contiguous, for the whole frame
- i_cmd_last  in  1  marks the last byte of the frame
- i_system_run  in  1  level; a rising edge loads the defaults
- i_adc_channel  in  CH_NUM  default channel mask
- i_adc_speed  in  SPEED_W  default divider
- i_adc_start  in  1  default enable
- i_adc_trig  in  1  default trigger mode
- o_cap_channel  out  CH_NUM  active channel mask
- o_cap_speed  out  SPEED_W  active divider
- o_cap_enable  out  1  capture enable
- o_cap_trig  out  1  trigger mode
- o_cap_seek  out  1  one-cycle seek pulse
- o_cmd_done  out  1  one-cycle pulse when a frame is committed
- o_cmd_err  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset: all outputs are 0. The state machine returns to S_TYPE. The run-edge detector history is cleared to 0.
- Frame format: byte0 = TYPE, byte1 = LEN, then LEN payload bytes (MSB first). i_cmd_last is on the final byte.
- Stage 1: all i_cmd_* inputs are registered. The parser operates on the registered copies.
- Commit: configuration outputs, o_cmd_done and o_cmd_err update on the clock edge 2 cycles after the edge that samples i_cmd_valid & i_cmd_last.
- State S_TYPE: on a valid byte, store TYPE and go to S_LEN.
  - If last is set on this byte, the frame is rejected with an error and the state stays in S_TYPE.
- State S_LEN: on a valid byte, store LEN and clear the payload shift register and byte counter.
  - If LEN = 0, LEN > MAX_LEN, or last is set on this byte: error. Go to S_DROP, or to S_TYPE if last was set.
  - Otherwise go to S_PAY.
- State S_PAY: each valid byte shifts into a 32-bit accumulator, acc = {acc[23:0], byte}, and the counter increments.
  - On last with count == LEN: validate and commit, then go to S_TYPE.
  - On last with count != LEN: error, go to S_TYPE.
  - If count reaches LEN without last: go to S_DROP and flag an error.
- State S_DROP: discard bytes until last, then pulse o_cmd_err and go to S_TYPE.
- Abort: i_cmd_valid low in any state other than S_TYPE before last is seen → o_cmd_err pulse, go to S_TYPE.
- Error pulse count: each rejected frame produces exactly one o_cmd_err pulse.
- TYPE 1, channel: o_cap_channel = acc[CH_NUM-1:0]. Excess bits are ignored.
- TYPE 2, speed: o_cap_speed = acc[SPEED_W-1:0]. A value of 0 is rejected as an error and the old value is kept.
- TYPE 3, enable: o_cap_enable = |acc[7:0].
- TYPE 4, trigger: o_cap_trig = |acc[7:0].
- TYPE 5, seek: o_cap_seek pulses high for exactly 1 cycle if acc[7:0] != 0. It does not assert again until the next seek frame.
- TYPE 6, reload: all configuration outputs are reloaded from the i_adc_* defaults.
- Any other TYPE: error. No configuration change.
- o_cmd_done pulses on every successful commit, including TYPE 5 with data 0.
- Run edge: a rising edge of registered i_system_run loads o_cap_channel, o_cap_speed, o_cap_enable and o_cap_trig from the defaults.
- Run edge coincident with a commit: the run-edge load wins, the frame is discarded, and o_cmd_err pulses.
- i_adc_start is the enable default. The enable is never loaded from the speed default.
- Reset mid-frame: the partial frame is discarded silently, with no error pulse.

Optional Feature:
- Macro: ADC_CMD_CHECKSUM_EN.
- When defined: every frame carries one extra trailing byte after the payload. This byte is the XOR of TYPE, LEN and all payload bytes, and it carries i_cmd_last. The counter check becomes count == LEN+1. A checksum mismatch rejects the frame with an o_cmd_err pulse.
- When undefined: there is no checksum byte and no checksum logic.

Test Plan:
- Reset, then pulse i_system_run with defaults channel 0xA5, speed 0x000400, start 1, trig 0 → outputs equal the defaults 2 cycles after the edge; done/err stay 0.
- Frame 02 03 01 86 A0 → o_cap_speed = 0x0186A0, one o_cmd_done pulse exactly 2 cycles after last; o_cap_channel unchanged.
- Frame 05 01 01 → o_cap_seek high for exactly 1 cycle. Frame 02 03 00 00 00 → o_cmd_err pulse, speed unchanged.
- Frame 01 05 ... with LEN > MAX_LEN, then frame 07 01 FF, then frame 01 02 0F (last too early) → three o_cmd_err pulses, no configuration change.
- Drop i_cmd_valid after byte 3 of a speed frame, then send 01 01 3C → one err pulse, then o_cap_channel = 0x3C with a done pulse.
- With ADC_CMD_CHECKSUM_EN: 03 01 01 03 → enable = 1 and done; 03 01 01 00 → err, enable unchanged.

Source files
------------

// File: rtl/adc_cmd_parser.sv
// adc_cmd_parser: turns host command frames (TYPE, LEN, payload) into
// capture configuration registers for the ADC capture core.
// Optional build macro: ADC_CMD_CHECKSUM_EN adds a trailing XOR byte per frame.
// Pipeline: p0 registers the raw link inputs, p1 is the frame parser and
// run-edge detector, p2 applies the decision to the outputs.
module adc_cmd_parser #(
  parameter int CH_NUM  = 8,
  parameter int SPEED_W = 24,
  parameter int MAX_LEN = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_cmd_data,
  input  logic               i_cmd_valid,
  input  logic               i_cmd_last,
  input  logic               i_system_run,
  input  logic [CH_NUM-1:0]  i_adc_channel,
  input  logic [SPEED_W-1:0] i_adc_speed,
  input  logic               i_adc_start,
  input  logic               i_adc_trig,
  output logic [CH_NUM-1:0]  o_cap_channel,
  output logic [SPEED_W-1:0] o_cap_speed,
  output logic               o_cap_enable,
  output logic               o_cap_trig,
  output logic               o_cap_seek,
  output logic               o_cmd_done,
  output logic               o_cmd_err
);

  typedef enum logic [1:0] {S_TYPE, S_LEN, S_PAY, S_DROP} state_t;

`ifdef ADC_CMD_CHECKSUM_EN
  localparam logic [8:0] TAIL = 9'd1;
`else
  localparam logic [8:0] TAIL = 9'd0;
`endif

  // ---- stage p0: registered link inputs ----
  logic [7:0] cmd_data_p0_q, cmd_data_p0_d;
  logic       vld_p0_q, vld_p0_d;
  logic       last_p0_q, last_p0_d;
  logic       run_p0_q, run_p0_d;

  // ---- stage p1: parser state and pending decision ----
  state_t      state_q, state_d;
  logic [7:0]  type_q, type_d;
  logic [7:0]  len_q, len_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic        commit_p1_q, commit_p1_d;
  logic        err_p1_q, err_p1_d;
  logic [7:0]  type_p1_q, type_p1_d;
  logic [31:0] acc_p1_q, acc_p1_d;
  logic        run_hist_q, run_hist_d;
  logic        run_edge_p1_q, run_edge_p1_d;
`ifdef ADC_CMD_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        pay_byte;
`endif

  // ---- stage p2: configuration outputs ----
  logic [CH_NUM-1:0]  cap_channel_q, cap_channel_d;
  logic [SPEED_W-1:0] cap_speed_q, cap_speed_d;
  logic               cap_enable_q, cap_enable_d;
  logic               cap_trig_q, cap_trig_d;
  logic               cap_seek_q, cap_seek_d;
  logic               cmd_done_q, cmd_done_d;
  logic               cmd_err_q, cmd_err_d;

  logic [31:0] acc_nxt;
  logic [8:0]  cnt_inc, frame_len;
  logic        len_bad, type_ok, frame_ok;
  logic        unused_bits;

  // Top accumulator byte shifts out; the p1 copy is only partly consumed.
  assign unused_bits = ^{acc_q[31:24], acc_p1_q};

  // Input capture: link bytes and run level are sampled once before parsing.
  always_comb begin
    cmd_data_p0_d = i_cmd_data;
    vld_p0_d      = i_cmd_valid;
    last_p0_d     = i_cmd_last;
    run_p0_d      = i_system_run;
  end

  // p0 registers; only the control bits are reset.
  always_ff @(posedge i_clk) begin
    cmd_data_p0_q <= cmd_data_p0_d;
    if (i_rst) begin
      vld_p0_q  <= 1'b0;
      last_p0_q <= 1'b0;
      run_p0_q  <= 1'b0;
    end else begin
      vld_p0_q  <= vld_p0_d;
      last_p0_q <= last_p0_d;
      run_p0_q  <= run_p0_d;
    end
  end

  // Byte counting, accumulator shift and frame validation terms.
  always_comb begin
    cnt_inc   = cnt_q + 9'd1;
    frame_len = {1'b0, len_q} + TAIL;
    len_bad   = (cmd_data_p0_q == 8'd0) || (32'(cmd_data_p0_q) > MAX_LEN);
`ifdef ADC_CMD_CHECKSUM_EN
    // The byte after the payload is the checksum and never enters acc.
    pay_byte  = (cnt_q < {1'b0, len_q});
    acc_nxt   = pay_byte ? {acc_q[23:0], cmd_data_p0_q} : acc_q;
`else
    acc_nxt   = {acc_q[23:0], cmd_data_p0_q};
`endif
    case (type_q)
      8'd1, 8'd3, 8'd4, 8'd5, 8'd6: type_ok = 1'b1;
      8'd2:                         type_ok = (acc_nxt[SPEED_W-1:0] != '0);
      default:                      type_ok = 1'b0;
    endcase
`ifdef ADC_CMD_CHECKSUM_EN
    frame_ok = type_ok && (csum_q == cmd_data_p0_q);
`else
    frame_ok = type_ok;
`endif
  end

  // Parser state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_TYPE;
    else       state_q <= state_d;
  end

  // Parser next state: any end of frame or loss of valid returns to S_TYPE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TYPE: if (vld_p0_q && !last_p0_q) state_d = S_LEN;
      S_LEN: begin
        if (!vld_p0_q || last_p0_q) state_d = S_TYPE;
        else if (len_bad)           state_d = S_DROP;
        else                        state_d = S_PAY;
      end
      S_PAY: begin
        if (!vld_p0_q || last_p0_q)   state_d = S_TYPE;
        else if (cnt_inc == frame_len) state_d = S_DROP;
      end
      S_DROP: if (!vld_p0_q || last_p0_q) state_d = S_TYPE;
      default: state_d = S_TYPE;
    endcase
  end

  // Parser outputs: field capture plus a single commit or error per frame,
  // raised only when the frame ends (last byte or abort).
  always_comb begin
    type_d      = type_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    commit_p1_d = 1'b0;
    err_p1_d    = 1'b0;
    type_p1_d   = type_q;
    acc_p1_d    = acc_nxt;
`ifdef ADC_CMD_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      S_TYPE: begin
        if (vld_p0_q) begin
          type_d   = cmd_data_p0_q;
          err_p1_d = last_p0_q;
`ifdef ADC_CMD_CHECKSUM_EN
          csum_d   = cmd_data_p0_q;
`endif
        end
      end
      S_LEN: begin
        if (!vld_p0_q) begin
          err_p1_d = 1'b1;
        end else begin
          len_d    = cmd_data_p0_q;
          cnt_d    = 9'd0;
          acc_d    = 32'd0;
          err_p1_d = last_p0_q;
`ifdef ADC_CMD_CHECKSUM_EN
          csum_d   = csum_q ^ cmd_data_p0_q;
`endif
        end
      end
      S_PAY: begin
        if (!vld_p0_q) begin
          err_p1_d = 1'b1;
        end else begin
          acc_d = acc_nxt;
          cnt_d = cnt_inc;
`ifdef ADC_CMD_CHECKSUM_EN
          if (pay_byte) csum_d = csum_q ^ cmd_data_p0_q;
`endif
          if (last_p0_q) begin
            if ((cnt_inc == frame_len) && frame_ok) commit_p1_d = 1'b1;
            else                                    err_p1_d    = 1'b1;
          end
        end
      end
      S_DROP: err_p1_d = !vld_p0_q || last_p0_q;
      default: ;
    endcase
  end

  // p1 registers: parser fields, pending decision and run-edge detector.
  always_ff @(posedge i_clk) begin
    type_q    <= type_d;
    len_q     <= len_d;
    cnt_q     <= cnt_d;
    acc_q     <= acc_d;
    type_p1_q <= type_p1_d;
    acc_p1_q  <= acc_p1_d;
`ifdef ADC_CMD_CHECKSUM_EN
    csum_q    <= csum_d;
`endif
    if (i_rst) begin
      commit_p1_q   <= 1'b0;
      err_p1_q      <= 1'b0;
      run_hist_q    <= 1'b0;
      run_edge_p1_q <= 1'b0;
    end else begin
      commit_p1_q   <= commit_p1_d;
      err_p1_q      <= err_p1_d;
      run_hist_q    <= run_hist_d;
      run_edge_p1_q <= run_edge_p1_d;
    end
  end

  // Rising edge of the registered run level.
  always_comb begin
    run_hist_d    = run_p0_q;
    run_edge_p1_d = run_p0_q && !run_hist_q;
  end

  // Output update: a run edge overrides and rejects a coinciding commit.
  always_comb begin
    cap_channel_d = cap_channel_q;
    cap_speed_d   = cap_speed_q;
    cap_enable_d  = cap_enable_q;
    cap_trig_d    = cap_trig_q;
    cap_seek_d    = 1'b0;
    cmd_done_d    = 1'b0;
    cmd_err_d     = 1'b0;
    if (run_edge_p1_q) begin
      cap_channel_d = i_adc_channel;
      cap_speed_d   = i_adc_speed;
      cap_enable_d  = i_adc_start;
      cap_trig_d    = i_adc_trig;
      cmd_err_d     = commit_p1_q || err_p1_q;
    end else if (commit_p1_q) begin
      cmd_done_d = 1'b1;
      case (type_p1_q)
        8'd1: cap_channel_d = acc_p1_q[CH_NUM-1:0];
        8'd2: cap_speed_d   = acc_p1_q[SPEED_W-1:0];
        8'd3: cap_enable_d  = |acc_p1_q[7:0];
        8'd4: cap_trig_d    = |acc_p1_q[7:0];
        8'd5: cap_seek_d    = |acc_p1_q[7:0];
        8'd6: begin
          cap_channel_d = i_adc_channel;
          cap_speed_d   = i_adc_speed;
          cap_enable_d  = i_adc_start;
          cap_trig_d    = i_adc_trig;
        end
        default: ;
      endcase
    end else begin
      cmd_err_d = err_p1_q;
    end
  end

  // ---- stage p2: output registers ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cap_channel_q <= '0;
      cap_speed_q   <= '0;
      cap_enable_q  <= 1'b0;
      cap_trig_q    <= 1'b0;
      cap_seek_q    <= 1'b0;
      cmd_done_q    <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      cap_channel_q <= cap_channel_d;
      cap_speed_q   <= cap_speed_d;
      cap_enable_q  <= cap_enable_d;
      cap_trig_q    <= cap_trig_d;
      cap_seek_q    <= cap_seek_d;
      cmd_done_q    <= cmd_done_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  assign o_cap_channel = cap_channel_q;
  assign o_cap_speed   = cap_speed_q;
  assign o_cap_enable  = cap_enable_q;
  assign o_cap_trig    = cap_trig_q;
  assign o_cap_seek    = cap_seek_q;
  assign o_cmd_done    = cmd_done_q;
  assign o_cmd_err     = cmd_err_q;

endmodule
